// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address-field width helpers for the instruction cache.
package cache_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int NUM_LINES      = 8;
    localparam int WORDS_PER_LINE = 4;

    function automatic int offset_width();
        return $clog2(WORDS_PER_LINE);
    endfunction

    function automatic int index_width();
        return $clog2(NUM_LINES);
    endfunction

    function automatic int tag_width();
        return WORD_SIZE - offset_width() - index_width();
    endfunction

    localparam int OFF_W = offset_width();
    localparam int IDX_W = index_width();
    localparam int TAG_W = tag_width();

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/icache_store.sv
// Tag, valid and data arrays of the direct-mapped cache: combinational read,
// single-word fill write, per-line tag/valid set and a global flush of the valid bits.
module icache_store
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     rd_index_i,
    input  logic [OFF_W-1:0]     rd_offset_i,
    output logic                 rd_valid_o,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic [WORD_SIZE-1:0] rd_word_o,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_index_i,
    input  logic [OFF_W-1:0]     wr_offset_i,
    input  logic [WORD_SIZE-1:0] wr_data_i,
    input  logic                 set_en_i,
    input  logic [TAG_W-1:0]     set_tag_i,
    input  logic                 set_valid_i,
    input  logic                 flush_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [WORD_SIZE-1:0] data_q [NUM_LINES*WORDS_PER_LINE];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_word_o  = data_q[{rd_index_i, rd_offset_i}];

    // Flush wins over a same-edge line set so a flushed fill never becomes valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (set_en_i) begin
            valid_q[wr_index_i] <= set_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
        end
        if (set_en_i) begin
            tag_q[wr_index_i] <= set_tag_i;
        end
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, word-by-word line fill
// on a miss, flush with fill poisoning, and saturating hit/miss counters.
module instruction_cache
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_readM,
    input  logic [WORD_SIZE-1:0] i_address,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 flush,
    output logic                 mem_readM,
    output logic [WORD_SIZE-1:0] mem_address,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_valid,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count,
    output logic                 state_o
);

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    state_t               state_q;
    logic [OFF_W-1:0]     beat_q;
    logic                 poison_q;
    logic [TAG_W-1:0]     fill_tag_q;
    logic [IDX_W-1:0]     fill_index_q;
    logic                 mem_readM_q;
    logic [WORD_SIZE-1:0] mem_address_q;
    logic [WORD_SIZE-1:0] hit_count_q;
    logic [WORD_SIZE-1:0] miss_count_q;

    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_index;
    logic [OFF_W-1:0]     req_offset;
    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [WORD_SIZE-1:0] rd_word;
    logic                 hit;
    logic                 beat_done;
    logic                 last_beat;

    assign req_tag    = i_address[WORD_SIZE-1 -: TAG_W];
    assign req_index  = i_address[OFF_W +: IDX_W];
    assign req_offset = i_address[OFF_W-1:0];

    assign hit       = i_readM && rd_valid && (rd_tag == req_tag) && (state_q == IDLE);
    assign beat_done = (state_q == FILL) && mem_valid;
    assign last_beat = beat_done && (beat_q == LAST_BEAT);

    assign i_ready     = hit;
    assign i_data      = hit ? rd_word : '0;
    assign mem_readM   = mem_readM_q;
    assign mem_address = mem_address_q;
    assign hit_count   = hit_count_q;
    assign miss_count  = miss_count_q;
    assign state_o     = state_q;

    icache_store u_store (
        .clk         (clk),
        .rst         (reset),
        .rd_index_i  (req_index),
        .rd_offset_i (req_offset),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_word_o   (rd_word),
        .wr_en_i     (beat_done),
        .wr_index_i  (fill_index_q),
        .wr_offset_i (beat_q),
        .wr_data_i   (mem_data),
        .set_en_i    (last_beat),
        .set_tag_i   (fill_tag_q),
        .set_valid_i (!(poison_q || flush)),
        .flush_i     (flush)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            poison_q      <= 1'b0;
            fill_tag_q    <= '0;
            fill_index_q  <= '0;
            mem_readM_q   <= 1'b0;
            mem_address_q <= '0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
        end else begin
            if (hit && (hit_count_q != '1)) begin
                hit_count_q <= hit_count_q + WORD_SIZE'(1);
            end
            case (state_q)
                IDLE: begin
                    poison_q <= 1'b0;
                    if (i_readM && !hit) begin
                        fill_tag_q    <= req_tag;
                        fill_index_q  <= req_index;
                        beat_q        <= '0;
                        mem_readM_q   <= 1'b1;
                        mem_address_q <= {req_tag, req_index, {OFF_W{1'b0}}};
                        state_q       <= FILL;
                        if (miss_count_q != '1) begin
                            miss_count_q <= miss_count_q + WORD_SIZE'(1);
                        end
                    end
                end
                FILL: begin
                    if (flush) begin
                        poison_q <= 1'b1;
                    end
                    if (last_beat) begin
                        poison_q      <= 1'b0;
                        mem_readM_q   <= 1'b0;
                        mem_address_q <= '0;
                        state_q       <= IDLE;
                    end else if (beat_done) begin
                        beat_q        <= beat_q + OFF_W'(1);
                        mem_address_q <= {fill_tag_q, fill_index_q, beat_q + OFF_W'(1)};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: fetch driver, memory responder, and a monitor that
// pops expected fill addresses and fetched words from queues as the DUT presents them.
module tb_instruction_cache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_readM = 1'b0;
    logic [15:0] i_address = '0;
    logic [15:0] i_data;
    logic        i_ready;
    logic        flush = 1'b0;
    logic        mem_readM;
    logic [15:0] mem_address;
    logic [15:0] mem_data = '0;
    logic        mem_valid = 1'b0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic        state_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] addr_q[$];
    logic [15:0] resp_q[$];

    instruction_cache dut (
        .clk         (clk),
        .reset       (reset),
        .i_readM     (i_readM),
        .i_address   (i_address),
        .i_data      (i_data),
        .i_ready     (i_ready),
        .flush       (flush),
        .mem_readM   (mem_readM),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], 8'h00} ^ a ^ 16'h3C5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted fill beat and every returned instruction is matched against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_readM && mem_valid) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fill_addr: unexpected beat at %0h", mem_address);
                end else begin
                    check("fill_addr", {16'h0, mem_address}, {16'h0, addr_q.pop_front()});
                end
            end
            if (i_ready) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_data: unexpected i_ready with data %0h", i_data);
                end else begin
                    check("fetch_data", {16'h0, i_data}, {16'h0, resp_q.pop_front()});
                end
            end
        end
    end

    // Called at posedge+1; holds the fetch until i_ready, serving memory beats every `period` fill cycles.
    task automatic do_fetch(input string name, input logic [15:0] addr, input int period,
                            input int n_fills, input int flush_beat, input bit flush_first,
                            input int exp_lat, input logic [15:0] exp_hits, input logic [15:0] exp_misses);
        int cycles;
        int phase;
        int accepted;
        bit flushed;
        bit done;
        logic [15:0] base;
        base = {addr[15:2], 2'b00};
        for (int f = 0; f < n_fills; f++)
            for (int b = 0; b < 4; b++) addr_q.push_back(base + 16'(b));
        resp_q.push_back(mem_fn(addr));
        i_readM = 1'b1;
        i_address = addr;
        flush = flush_first;
        mem_valid = 1'b0;
        mem_data = '0;
        cycles = 1;
        phase = 0;
        accepted = 0;
        flushed = 1'b0;
        done = 1'b0;
        while (!done && cycles <= 40) begin
            @(negedge clk);
            if (i_ready) begin
                done = 1'b1;
                check({name, "_latency"}, 32'(cycles), 32'(exp_lat));
                check({name, "_hit_count"}, {16'h0, hit_count}, {16'h0, exp_hits});
                check({name, "_miss_count"}, {16'h0, miss_count}, {16'h0, exp_misses});
            end else begin
                @(posedge clk);
                #1;
                cycles++;
                flush = 1'b0;
                if (mem_readM) begin
                    phase++;
                    mem_valid = (phase % period) == 0;
                end else begin
                    mem_valid = 1'b0;
                end
                mem_data = mem_valid ? mem_fn(mem_address) : 16'h0;
                if (mem_valid && accepted == flush_beat && !flushed) begin
                    flush = 1'b1;
                    flushed = 1'b1;
                end
                if (mem_valid) accepted++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no i_ready after %0d cycles, expected %0d", name, cycles, exp_lat);
        end
        @(posedge clk);
        #1;
        i_readM = 1'b0;
        flush = 1'b0;
        mem_valid = 1'b0;
        mem_data = '0;
    endtask

    initial begin
        #1;
        check("rst_i_ready", {31'h0, i_ready}, 32'h0);
        check("rst_i_data", {16'h0, i_data}, 32'h0);
        check("rst_mem_readM", {31'h0, mem_readM}, 32'h0);
        check("rst_mem_address", {16'h0, mem_address}, 32'h0);
        check("rst_hit_count", {16'h0, hit_count}, 32'h0);
        check("rst_miss_count", {16'h0, miss_count}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        do_fetch("cold_miss", 16'h0000, 1, 1, -1, 1'b0, 6, 16'd0, 16'd1);
        do_fetch("hit_w2", 16'h0002, 1, 0, -1, 1'b0, 1, 16'd1, 16'd1);
        do_fetch("conflict", 16'h0020, 1, 1, -1, 1'b0, 6, 16'd2, 16'd2);
        do_fetch("refetch0", 16'h0000, 1, 1, -1, 1'b0, 6, 16'd3, 16'd3);
        do_fetch("slow_mem", 16'h0105, 3, 1, -1, 1'b0, 14, 16'd4, 16'd4);

        // Stray mem_valid while idle and not fetching must change nothing.
        mem_valid = 1'b1;
        mem_data = 16'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        mem_valid = 1'b0;
        check("idle_memvalid_miss", {16'h0, miss_count}, 32'd4);
        check("idle_memvalid_hit", {16'h0, hit_count}, 32'd5);
        check("idle_memvalid_state", {31'h0, state_o}, 32'h0);
        do_fetch("slow_line_hit", 16'h0106, 1, 0, -1, 1'b0, 1, 16'd5, 16'd4);

        // Flush during beat 2 poisons the fill: the fetch misses again and refills.
        do_fetch("flush_fill", 16'h0043, 1, 2, 2, 1'b0, 11, 16'd6, 16'd6);
        do_fetch("flush_idle_hit", 16'h0041, 1, 0, -1, 1'b1, 1, 16'd7, 16'd6);
        do_fetch("after_idle_flush", 16'h0041, 1, 1, -1, 1'b0, 6, 16'd8, 16'd7);

        // Reset during beat 1 of a fill.
        addr_q.push_back(16'h0104);
        i_readM = 1'b1;
        i_address = 16'h0104;
        @(posedge clk);
        #1;
        check("fill_started", {31'h0, mem_readM}, 32'h1);
        mem_valid = 1'b1;
        mem_data = mem_fn(16'h0104);
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_data = mem_fn(16'h0105);
        #2;
        reset = 1'b1;
        #1;
        check("midfill_rst_mem_readM", {31'h0, mem_readM}, 32'h0);
        check("midfill_rst_mem_address", {16'h0, mem_address}, 32'h0);
        check("midfill_rst_i_ready", {31'h0, i_ready}, 32'h0);
        check("midfill_rst_i_data", {16'h0, i_data}, 32'h0);
        i_readM = 1'b0;
        mem_valid = 1'b0;
        mem_data = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_rst_hit_count", {16'h0, hit_count}, 32'h0);
        check("post_rst_miss_count", {16'h0, miss_count}, 32'h0);
        check("post_rst_state", {31'h0, state_o}, 32'h0);
        do_fetch("post_rst_miss", 16'h0104, 1, 1, -1, 1'b0, 6, 16'd0, 16'd1);

        repeat (2) @(posedge clk);
        check("addr_q_drained", 32'(addr_q.size()), 32'h0);
        check("resp_q_drained", 32'(resp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
